serial_subtractor_ctrl: RTL
===========================

// Module: serial_subtractor_ctrl
// PURPOSE
//  Sequences one full-subtractor cell (dif=a^b^cin, borrow=~a&b | cin&~(a^b))
//  bit-serially, LSB first, to compute an N-bit difference A-B with a stored borrow.
//  Sits between a requester using a start/busy/done handshake and the shared
//  1-bit subtractor datapath. It trades N cycles of latency for a single cell.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=2)
// PORTS
//  clk         in   1      single clock; all state updates on posedge
//  rst         in   1      reset, synchronous, active-high
//  start       in   1      request; sampled only in IDLE
//  a_in        in   WIDTH  minuend, captured on accepted start
//  b_in        in   WIDTH  subtrahend, captured on accepted start
//  busy        out  1      high in SHIFT and DONE states
//  done        out  1      one-cycle pulse: result valid
//  dif_out     out  WIDTH  A-B mod 2^WIDTH, held until next completion
//  borrow_out  out  1      final borrow (1 iff A<B unsigned), held with dif_out
// BEHAVIOUR
//  Reset: state=IDLE; busy=0; done=0; dif_out=0; borrow_out=0.
//  Reset: internal shift regs, borrow flop and bit counter all cleared.
//  Reset has priority over every other input.
//  FSM states:
//   IDLE -> SHIFT on start=1. Capture a_in/b_in; borrow flop=0; count=0.
//   SHIFT, one bit per cycle:
//    - d  = a_sh[0]^b_sh[0]^br
//    - br <= (~a_sh[0]&b_sh[0]) | (br&~(a_sh[0]^b_sh[0]))
//    - res_sh <= {d, res_sh[WIDTH-1:1]}; a_sh, b_sh shift right by 1
//    - count <= count+1
//   SHIFT -> DONE when processing bit WIDTH-1 (count==WIDTH-1).
//    - Load dif_out with the final shifted result, including that bit.
//    - Load borrow_out with the borrow out of that bit.
//   DONE -> IDLE unconditionally. done=1 only in DONE.
//  Latency: start sampled at edge k -> done high in cycle k+WIDTH+1.
//   busy high for WIDTH+1 cycles.
//  Throughput: a new start is accepted the cycle after done.
//   Minimum period is WIDTH+2 cycles.
//  start while busy (SHIFT or DONE): ignored, no side effects.
//   a_in/b_in changes while busy do not affect the result.
//  dif_out/borrow_out change only on the SHIFT->DONE edge.
//   They hold through IDLE and the following SHIFT.
//  Counter width: $clog2(WIDTH). The counter never wraps in SHIFT.
//  Arithmetic is unsigned modulo 2^WIDTH. Signed callers use dif_out as
//   the two's-complement difference; borrow_out is not an overflow flag.
//  Reset mid-SHIFT: abort the operation.
//   done is not asserted. dif_out/borrow_out return to 0.
// TESTING (WIDTH=8)
//  1. a=10, b=3, start 1 cycle.
//     -> busy 9 cycles; done at start+9; dif_out=8'h07; borrow_out=0.
//  2. a=3, b=10 -> dif_out=8'hF9, borrow_out=1.
//     Also a=0, b=1 -> dif_out=8'hFF, borrow_out=1.
//  3. a=b=8'hAA -> dif_out=0, borrow_out=0.
//     Also a=8'h80, b=8'h7F -> dif_out=8'h01, borrow_out=0.
//  4. Pulse start again at start+3 with a=1, b=1.
//     -> ignored; result from first operands only; one done pulse.
//  5. Assert rst at start+4. -> next cycle busy=0, done=0, dif_out=0.
//     No done pulse; a fresh start then completes normally.
//  6. Back-to-back: start held high continuously.
//     -> new operation accepted every 10 cycles; dif_out stable between dones.
//     Random sweep vs A-B reference model, 1000 vectors.

Source files
------------

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor controller: sequences a single full-subtractor cell
// over WIDTH cycles, LSB first, behind a start/busy/done handshake.
module serial_subtractor_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] dif_out,
   output logic             borrow_out
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] res_sh_r;
   logic             br_r;
   logic [CW-1:0]    count_r;

   logic             dif_s;
   logic             br_next_s;
   logic [WIDTH-1:0] res_next_s;

   function automatic logic [1:0] fs_cell(input logic a, input logic b, input logic cin);
      logic d;
      logic bo;
      d  = a ^ b ^ cin;
      bo = (~a & b) | (cin & ~(a ^ b));
      return {bo, d};
   endfunction

   // Shared cell evaluated on the current operand LSBs and the stored borrow
   always_comb begin
      {br_next_s, dif_s} = fs_cell(a_sh_r[0], b_sh_r[0], br_r);
      res_next_s         = {dif_s, res_sh_r[WIDTH-1:1]};
   end

   // Sequencer, serial datapath registers and registered handshake/result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         a_sh_r     <= {WIDTH{1'b0}};
         b_sh_r     <= {WIDTH{1'b0}};
         res_sh_r   <= {WIDTH{1'b0}};
         br_r       <= 1'b0;
         count_r    <= {CW{1'b0}};
         busy       <= 1'b0;
         done       <= 1'b0;
         dif_out    <= {WIDTH{1'b0}};
         borrow_out <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh_r  <= a_in;
                  b_sh_r  <= b_in;
                  br_r    <= 1'b0;
                  count_r <= {CW{1'b0}};
                  busy    <= 1'b1;
                  state_r <= SHIFT;
               end else begin
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end
            end
            SHIFT: begin
               a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
               b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
               br_r     <= br_next_s;
               res_sh_r <= res_next_s;
               // The counter stops on the last bit instead of wrapping
               if (count_r == LAST_BIT) begin
                  dif_out    <= res_next_s;
                  borrow_out <= br_next_s;
                  done       <= 1'b1;
                  state_r    <= DONE;
               end else begin
                  count_r <= count_r + CW'(1);
                  state_r <= SHIFT;
               end
            end
            DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
